uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4; number of requesters, range 2..8.
REQ-002 SHALL have parameter GAP_CYCLES, default 16; idle clocks inserted after each frame, range 0..65535.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000; maximum stall of the granted requester mid-frame, range 1..65535.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits; bit i set means requester i offers a byte.
REQ-007 SHALL have port req_data, input, 8*NUM_REQ bits; byte of requester i is at bits [8i+7:8i].
REQ-008 SHALL have port req_last, input, NUM_REQ bits; bit i marks the offered byte as the last byte of its frame.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits; bit i set means requester i's byte is accepted this cycle.
REQ-010 SHALL have port tx_data, output, 8 bits; byte to the UART transmitter.
REQ-011 SHALL have port tx_data_valid, output, 1 bit; byte on tx_data is valid.
REQ-012 SHALL have port tx_data_ready, input, 1 bit; the UART transmitter is idle and accepts a byte.
REQ-013 SHALL have port grant, output, 3 bits; index of the current or last granted requester.
REQ-014 SHALL have port busy, output, 1 bit; high in any state other than IDLE.
REQ-015 SHALL have port timeout_err, output, 1 bit; one-cycle pulse when a frame is aborted.

Function
REQ-016 SHALL implement a state machine with states IDLE, SEND, GAP.
REQ-017 In IDLE with any req_valid bit set, SHALL select a requester by round-robin.
- Search order starts at (last grant + 1) mod NUM_REQ and wraps.
- The selected index SHALL be registered into grant, and the state SHALL move to SEND on the next edge.
REQ-018 In IDLE with no req_valid bit set, SHALL remain in IDLE and leave grant unchanged.
REQ-019 In SEND, the following SHALL be combinational from the granted requester g:
- tx_data = req_data[g].
- tx_data_valid = req_valid[g].
- req_ready[g] = req_valid[g] AND tx_data_ready.
- All other req_ready bits = 0.
REQ-020 Outside SEND, tx_data_valid and all req_ready bits SHALL be 0, and tx_data SHALL hold 8'h00.
REQ-021 A byte transfer SHALL occur in any SEND cycle with tx_data_valid AND tx_data_ready both high; each transfer moves exactly one byte.
REQ-022 On a transfer with req_last[g] high, SHALL leave SEND:
- to GAP if GAP_CYCLES > 0;
- to IDLE if GAP_CYCLES = 0.
REQ-023 Grant SHALL be held for the whole frame; other requesters' valid bits SHALL be ignored until the frame completes.
REQ-024 SHALL maintain a 16-bit stall counter in SEND.
- It clears on each transfer and on entry to SEND.
- It increments in every SEND cycle in which req_valid[g] is low.
- It does not increment while req_valid[g] is high and the UART is busy.
REQ-025 When the stall counter reaches TIMEOUT_CYCLES - 1 while req_valid[g] is low, SHALL:
- pulse timeout_err for one cycle;
- abort the frame and go to GAP (or to IDLE if GAP_CYCLES = 0).
REQ-026 In GAP, SHALL count GAP_CYCLES clocks with a 16-bit counter, then return to IDLE; req_valid SHALL be ignored during GAP.
REQ-027 On the IDLE->SEND edge, the last-grant pointer SHALL update to the new grant.
REQ-028 If req_last[g] is high on a byte while tx_data_ready is low, SHALL not end the frame; the frame ends only on the transfer cycle.
REQ-029 If req_valid[g] drops while tx_data_ready is low, SHALL treat the drop as a stall, per REQ-024.
REQ-030 When a single requester is continuously active, SHALL re-grant it after GAP if no other requester is valid.

Reset
REQ-031 On rst high at a rising edge, SHALL apply the following regardless of state, including mid-frame:
- state = IDLE;
- grant = 0;
- last-grant pointer = NUM_REQ-1, so requester 0 has first priority;
- stall and gap counters = 0;
- timeout_err = 0.
REQ-032 During and after reset, busy, tx_data_valid and req_ready SHALL be 0 until a new grant occurs.

Verification
REQ-033 Bench SHALL cover simultaneous requests.
- Stimulus: after reset, requesters 0 and 2 valid simultaneously, each sending a 3-byte frame.
- Response: requester 0 is served first, then requester 2.
- Each frame is followed by GAP_CYCLES idle clocks, with busy high throughout.
REQ-034 Bench SHALL cover round-robin fairness.
- Stimulus: all 4 requesters constantly valid with 1-byte frames.
- Response: grant sequence is 0,1,2,3,0.
REQ-035 Bench SHALL cover backpressure.
- Stimulus: tx_data_ready held low for 100 cycles mid-frame, with byte 8'hA5 offered.
- Response: req_ready stays 0 and no transfer occurs.
- When tx_data_ready goes high, 8'hA5 transfers in that cycle.
REQ-036 Bench SHALL cover timeout.
- Stimulus: TIMEOUT_CYCLES=10; granted requester drops valid after byte 1 of a 3-byte frame.
- Response: timeout_err pulses 10 cycles later, the state enters GAP, and the next requester is granted afterwards.
REQ-037 Bench SHALL cover reset mid-frame.
- Stimulus: rst asserted during byte 2 of a frame from requester 1.
- Response: the next cycle has busy=0, tx_data_valid=0, grant=0.
- A subsequent request from requester 1 is granted from IDLE.
REQ-038 Bench SHALL cover GAP_CYCLES=0.
- Stimulus: back-to-back frames from requesters 0 and 1.
- Response: the next grant occurs in the first IDLE cycle after the last transfer.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges byte streams from several requesters onto one
// UART transmitter. A grant lasts a whole frame; an optional idle gap follows each
// frame; a stalled frame is aborted after a configurable number of idle cycles.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ready,
  output logic [2:0]           grant,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  localparam logic [15:0] StallMax = 16'(TIMEOUT_CYCLES - 1);
  // Unused when GAP_CYCLES is 0 because the GAP state is then never entered.
  localparam logic [15:0] GapMax   = 16'(GAP_CYCLES - 1);
  localparam logic [2:0]  LastInit = 3'(NUM_REQ - 1);
  localparam state_e      EndState = (GAP_CYCLES > 0) ? StGap : StIdle;

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  last_q, last_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] gap_q, gap_d;
  logic        terr_q, terr_d;

  logic        g_valid, g_last;
  logic [7:0]  g_data;
  logic        sel_found;
  logic [2:0]  sel_idx;
  logic        xfer;

  // Select the granted requester's valid/last/data.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  // Round-robin pick: first scan indices above the last grant, then wrap to the rest.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!sel_found && req_valid[k] && (3'(k) > last_q)) begin
        sel_found = 1'b1;
        sel_idx   = 3'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!sel_found && req_valid[k] && (3'(k) <= last_q)) begin
        sel_found = 1'b1;
        sel_idx   = 3'(k);
      end
    end
  end

  assign xfer = (state_q == StSend) && g_valid && tx_data_ready;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= LastInit;
      stall_q <= '0;
      gap_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic: grant on idle, frame end / stall abort in send, gap countdown.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    stall_d = stall_q;
    gap_d   = gap_q;
    terr_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d = StSend;
          grant_d = sel_idx;
          last_d  = sel_idx;
          stall_d = '0;
        end
      end
      StSend: begin
        if (xfer) begin
          stall_d = '0;
          if (g_last) begin
            state_d = EndState;
            gap_d   = '0;
          end
        end else if (!g_valid) begin
          // Only an absent byte counts as a stall; a busy UART does not.
          if (stall_q >= StallMax) begin
            terr_d  = 1'b1;
            state_d = EndState;
            stall_d = '0;
            gap_d   = '0;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end
      end
      StGap: begin
        if (gap_q >= GapMax) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: the granted requester is connected straight through while sending.
  always_comb begin
    req_ready     = '0;
    tx_data       = 8'h00;
    tx_data_valid = 1'b0;
    if (state_q == StSend) begin
      tx_data       = g_data;
      tx_data_valid = g_valid;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == 3'(i)) begin
          req_ready[i] = g_valid && tx_data_ready;
        end
      end
    end
    busy        = (state_q != StIdle);
    grant       = grant_q;
    timeout_err = terr_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Three instances share the stimulus:
// d0 default parameters, d1 short timeout with a 4-cycle gap, d2 no gap.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        tx_data_ready;

  logic [3:0] d0_req_ready, d1_req_ready, d2_req_ready;
  logic [7:0] d0_tx_data, d1_tx_data, d2_tx_data;
  logic       d0_tx_valid, d1_tx_valid, d2_tx_valid;
  logic [2:0] d0_grant, d1_grant, d2_grant;
  logic       d0_busy, d1_busy, d2_busy;
  logic       d0_terr, d1_terr, d2_terr;

  logic [1:0] sel;
  logic [3:0] m_req_ready;
  logic [7:0] m_tx_data;
  logic       m_tx_valid;
  logic [2:0] m_grant;
  logic       m_busy;
  logic       m_terr;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester model state for the frame-driven tests.
  int len_q[4];
  int ptr[4];
  int left[4];
  int          xfer_cyc[$];
  logic [2:0]  xfer_gnt[$];
  logic [7:0]  xfer_dat[$];
  logic        busy_log[$];

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(16), .TIMEOUT_CYCLES(50000)) u_d0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(d0_req_ready), .tx_data(d0_tx_data), .tx_data_valid(d0_tx_valid),
    .tx_data_ready(tx_data_ready), .grant(d0_grant), .busy(d0_busy), .timeout_err(d0_terr)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(4), .TIMEOUT_CYCLES(10)) u_d1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(d1_req_ready), .tx_data(d1_tx_data), .tx_data_valid(d1_tx_valid),
    .tx_data_ready(tx_data_ready), .grant(d1_grant), .busy(d1_busy), .timeout_err(d1_terr)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(50000)) u_d2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(d2_req_ready), .tx_data(d2_tx_data), .tx_data_valid(d2_tx_valid),
    .tx_data_ready(tx_data_ready), .grant(d2_grant), .busy(d2_busy), .timeout_err(d2_terr)
  );

  always_comb begin
    case (sel)
      2'd1: begin
        m_req_ready = d1_req_ready; m_tx_data = d1_tx_data; m_tx_valid = d1_tx_valid;
        m_grant = d1_grant; m_busy = d1_busy; m_terr = d1_terr;
      end
      2'd2: begin
        m_req_ready = d2_req_ready; m_tx_data = d2_tx_data; m_tx_valid = d2_tx_valid;
        m_grant = d2_grant; m_busy = d2_busy; m_terr = d2_terr;
      end
      default: begin
        m_req_ready = d0_req_ready; m_tx_data = d0_tx_data; m_tx_valid = d0_tx_valid;
        m_grant = d0_grant; m_busy = d0_busy; m_terr = d0_terr;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      len_q[i] = 1;
      ptr[i]   = 0;
      left[i]  = 0;
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    req_last      = '0;
    tx_data_ready = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_model();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (left[i] > 0);
      req_data[8*i +: 8] = 8'(64 + 16 * i + ptr[i]);
      req_last[i]        = (ptr[i] == len_q[i] - 1);
    end
  endtask

  // Runs the requester model; records every transfer and the busy flag per cycle.
  task automatic run_model(input int max_cycles, input int stop_after);
    logic [3:0] rdy;
    xfer_cyc.delete();
    xfer_gnt.delete();
    xfer_dat.delete();
    busy_log.delete();
    for (int c = 0; c < max_cycles; c++) begin
      drive_model();
      #1;
      rdy = m_req_ready;
      busy_log.push_back(m_busy);
      if (m_tx_valid && tx_data_ready) begin
        xfer_cyc.push_back(c);
        xfer_gnt.push_back(m_grant);
        xfer_dat.push_back(m_tx_data);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) begin
          ptr[i]++;
          if (ptr[i] == len_q[i]) begin
            ptr[i] = 0;
            left[i]--;
          end
        end
      end
      if (xfer_cyc.size() >= stop_after) break;
    end
  endtask

  task automatic test_reset();
    sel           = 2'd0;
    rst           = 1'b1;
    req_valid     = 4'hF;
    req_data      = 32'h44332211;
    req_last      = 4'hF;
    tx_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (d0_busy !== 1'b0 || d2_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b/%b want 0/0", d0_busy, d2_busy);
    end
    n_tests++;
    if (d0_req_ready !== 4'h0 || d0_tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_valid: got %h/%b want 0/0", d0_req_ready, d0_tx_valid);
    end
    n_tests++;
    if (d0_grant !== 3'd0 || d0_terr !== 1'b0 || d0_tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_regs: grant %0d terr %b data %h want 0 0 00",
               d0_grant, d0_terr, d0_tx_data);
    end
    req_valid = '0;
    rst       = 1'b0;
    next_cycle();
    n_tests++;
    if (d0_busy !== 1'b0 || d0_grant !== 3'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy %b grant %0d want 0 0", d0_busy, d0_grant);
    end
  endtask

  task automatic test_simultaneous();
    int exp_c[6] = '{1, 2, 3, 21, 22, 23};
    int exp_g[6] = '{0, 0, 0, 2, 2, 2};
    int exp_d[6] = '{8'h40, 8'h41, 8'h42, 8'h60, 8'h61, 8'h62};
    int busy_err;
    logic exp_busy;
    sel = 2'd0;
    do_reset();
    len_q[0] = 3; left[0] = 1;
    len_q[2] = 3; left[2] = 1;
    run_model(45, 99);
    n_tests++;
    if (xfer_cyc.size() != 6) begin
      n_fail++;
      $display("FAIL simul_count: got %0d transfers want 6", xfer_cyc.size());
    end
    for (int k = 0; k < 6 && k < xfer_cyc.size(); k++) begin
      n_tests++;
      if (xfer_cyc[k] != exp_c[k] || xfer_gnt[k] !== 3'(exp_g[k]) ||
          xfer_dat[k] !== 8'(exp_d[k])) begin
        n_fail++;
        $display("FAIL simul_xfer%0d: got cyc %0d g %0d d %h want cyc %0d g %0d d %h", k,
                 xfer_cyc[k], xfer_gnt[k], xfer_dat[k], exp_c[k], exp_g[k], exp_d[k]);
      end
    end
    busy_err = 0;
    for (int c = 0; c < 45; c++) begin
      exp_busy = (c >= 1 && c <= 19) || (c >= 21 && c <= 39);
      if (busy_log[c] !== exp_busy) busy_err++;
    end
    n_tests++;
    if (busy_err != 0) begin
      n_fail++;
      $display("FAIL simul_busy: got %0d wrong busy cycles want 0", busy_err);
    end
  endtask

  task automatic test_round_robin();
    int exp_c[5] = '{1, 19, 37, 55, 73};
    int exp_g[5] = '{0, 1, 2, 3, 0};
    sel = 2'd0;
    do_reset();
    for (int i = 0; i < 4; i++) left[i] = 2;
    run_model(200, 5);
    n_tests++;
    if (xfer_gnt.size() != 5) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants want 5", xfer_gnt.size());
    end
    for (int k = 0; k < 5 && k < xfer_gnt.size(); k++) begin
      n_tests++;
      if (xfer_gnt[k] !== 3'(exp_g[k]) || xfer_cyc[k] != exp_c[k]) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got g %0d cyc %0d want g %0d cyc %0d", k,
                 xfer_gnt[k], xfer_cyc[k], exp_g[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int hold_err;
    sel = 2'd0;
    do_reset();
    req_valid = 4'b0010;
    req_data  = 32'h00005000;
    req_last  = 4'b0000;
    next_cycle();
    #1;
    n_tests++;
    if (d0_req_ready !== 4'b0010 || d0_tx_data !== 8'h50) begin
      n_fail++;
      $display("FAIL bp_first: ready %b data %h want 0010 50", d0_req_ready, d0_tx_data);
    end
    next_cycle();
    req_data      = 32'h0000A500;
    req_last      = 4'b0010;
    tx_data_ready = 1'b0;
    hold_err      = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (d0_req_ready !== 4'h0 || d0_tx_valid !== 1'b1 || d0_tx_data !== 8'hA5 ||
          d1_terr !== 1'b0 || d1_req_ready !== 4'h0 || d0_busy !== 1'b1) hold_err++;
      next_cycle();
    end
    n_tests++;
    if (hold_err != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d bad stall cycles want 0", hold_err);
    end
    tx_data_ready = 1'b1;
    #1;
    n_tests++;
    if (d0_req_ready !== 4'b0010 || d0_tx_data !== 8'hA5 || d1_req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release: ready %b/%b data %h want 0010/0010 a5",
               d0_req_ready, d1_req_ready, d0_tx_data);
    end
    next_cycle();
    req_valid = '0;
    #1;
    n_tests++;
    if (d0_busy !== 1'b1 || d0_tx_valid !== 1'b0 || d0_tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL bp_gap: busy %b valid %b data %h want 1 0 00",
               d0_busy, d0_tx_valid, d0_tx_data);
    end
  endtask

  task automatic test_timeout();
    int first_hit;
    int hits;
    int hold_err;
    sel = 2'd1;
    do_reset();
    req_valid = 4'b0011;
    req_data  = 32'h00008070;
    req_last  = 4'b0010;
    next_cycle();
    #1;
    n_tests++;
    if (m_tx_valid !== 1'b1 || m_tx_data !== 8'h70 || m_req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL to_byte1: valid %b data %h ready %b want 1 70 0001",
               m_tx_valid, m_tx_data, m_req_ready);
    end
    next_cycle();
    req_valid = 4'b0010;
    first_hit = -1;
    hits      = 0;
    hold_err  = 0;
    for (int c = 2; c <= 17; c++) begin
      #1;
      if (m_terr === 1'b1) begin
        hits++;
        if (first_hit < 0) first_hit = c;
      end
      if (c <= 11 && (m_grant !== 3'd0 || m_req_ready !== 4'h0 || m_busy !== 1'b1)) hold_err++;
      if (c == 12) begin
        n_tests++;
        if (m_busy !== 1'b1 || m_tx_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL to_gap: busy %b valid %b want 1 0", m_busy, m_tx_valid);
        end
      end
      if (c == 17) begin
        n_tests++;
        if (m_grant !== 3'd1 || m_tx_valid !== 1'b1 || m_tx_data !== 8'h80) begin
          n_fail++;
          $display("FAIL to_next_grant: grant %0d valid %b data %h want 1 1 80",
                   m_grant, m_tx_valid, m_tx_data);
        end
      end
      next_cycle();
    end
    n_tests++;
    if (first_hit != 12 || hits != 1) begin
      n_fail++;
      $display("FAIL to_pulse: got cycle %0d count %0d want cycle 12 count 1", first_hit, hits);
    end
    n_tests++;
    if (hold_err != 0) begin
      n_fail++;
      $display("FAIL to_hold: got %0d bad stall cycles want 0", hold_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    sel = 2'd0;
    do_reset();
    req_valid = 4'b0010;
    req_data  = 32'h00009000;
    req_last  = 4'b0000;
    next_cycle();
    #1;
    n_tests++;
    if (m_grant !== 3'd1 || m_tx_data !== 8'h90 || m_req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL rmf_byte1: grant %0d data %h ready %b want 1 90 0010",
               m_grant, m_tx_data, m_req_ready);
    end
    next_cycle();
    req_data = 32'h00009100;
    rst      = 1'b1;
    next_cycle();
    rst      = 1'b0;
    req_data = 32'h00009000;
    #1;
    n_tests++;
    if (m_busy !== 1'b0 || m_tx_valid !== 1'b0 || m_grant !== 3'd0 || m_req_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL rmf_after_rst: busy %b valid %b grant %0d ready %b want 0 0 0 0000",
               m_busy, m_tx_valid, m_grant, m_req_ready);
    end
    next_cycle();
    #1;
    n_tests++;
    if (m_grant !== 3'd1 || m_tx_valid !== 1'b1 || m_tx_data !== 8'h90 || m_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmf_regrant: grant %0d valid %b data %h busy %b want 1 1 90 1",
               m_grant, m_tx_valid, m_tx_data, m_busy);
    end
  endtask

  task automatic test_gap_zero();
    int exp_c[4] = '{1, 2, 4, 5};
    int exp_g[4] = '{0, 0, 1, 1};
    int exp_d[4] = '{8'h40, 8'h41, 8'h50, 8'h51};
    sel = 2'd2;
    do_reset();
    len_q[0] = 2; left[0] = 1;
    len_q[1] = 2; left[1] = 1;
    run_model(10, 99);
    n_tests++;
    if (xfer_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL g0_count: got %0d transfers want 4", xfer_cyc.size());
    end
    for (int k = 0; k < 4 && k < xfer_cyc.size(); k++) begin
      n_tests++;
      if (xfer_cyc[k] != exp_c[k] || xfer_gnt[k] !== 3'(exp_g[k]) ||
          xfer_dat[k] !== 8'(exp_d[k])) begin
        n_fail++;
        $display("FAIL g0_xfer%0d: got cyc %0d g %0d d %h want cyc %0d g %0d d %h", k,
                 xfer_cyc[k], xfer_gnt[k], xfer_dat[k], exp_c[k], exp_g[k], exp_d[k]);
      end
    end
    n_tests++;
    if (busy_log[3] !== 1'b0 || busy_log[6] !== 1'b0) begin
      n_fail++;
      $display("FAIL g0_idle: busy c3 %b c6 %b want 0 0", busy_log[3], busy_log[6]);
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_frame();
    test_gap_zero();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
